// File: rtl/sha256_config_join.sv
// Joins the SHA-256 ID stream and config stream into one registered config record per cycle.
// Latency: both inputs accepted at edge N -> cfg_out_valid after edge N+1; readies = en & !sync_rst & !full.
// Optional SHA256_CFG_JOIN_LAST_CHECK_EN adds a sticky err_last_mismatch flag comparing the two last flags.

module sha256_cfg_join_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdat,
  output logic [W-1:0]             rdat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdat  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdat;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

module sha256_config_join #(
  parameter int ID_W     = 6,
  parameter int SIZE_W   = 64,
  parameter int SCHEME_W = 2,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      sync_rst,
  input  logic [ID_W-1:0]           id_in,
  input  logic                      id_in_last,
  input  logic                      id_in_valid,
  output logic                      id_in_ready,
  input  logic [SIZE_W-1:0]         cfg_in_size,
  input  logic [SCHEME_W-1:0]       cfg_in_scheme,
  input  logic                      cfg_in_last,
  input  logic                      cfg_in_valid,
  output logic                      cfg_in_ready,
  output logic [SIZE_W-1:0]         cfg_out_size,
  output logic [SCHEME_W-1:0]       cfg_out_scheme,
  output logic [ID_W-1:0]           cfg_out_id,
  output logic                      cfg_out_last,
  output logic                      cfg_out_valid,
  input  logic                      cfg_out_ready,
  output logic [$clog2(DEPTH):0]    id_level,
  output logic [$clog2(DEPTH):0]    cfg_level,
  output logic [SIZE_W-1:0]         status_size,
  output logic                      status_valid
`ifdef SHA256_CFG_JOIN_LAST_CHECK_EN
  ,
  output logic                      err_last_mismatch
`endif
);
`ifdef SHA256_CFG_JOIN_LAST_CHECK_EN
  localparam int IW = ID_W + 1;
`else
  localparam int IW = ID_W;
`endif

  typedef struct packed {
    logic [SIZE_W-1:0]   size;
    logic [SCHEME_W-1:0] scheme;
    logic                last;
  } cfg_t;

  typedef struct packed {
    cfg_t            cfg;
    logic [ID_W-1:0] id;
  } rec_t;

  logic          id_full, id_empty, cfg_full, cfg_empty;
  logic          id_push, cfg_push, load, hs;
  logic [IW-1:0] id_wdat, id_head;
  cfg_t          cfg_wdat, cfg_head;

  rec_t              rec_q, rec_d;
  logic              out_vld_q, out_vld_d;
  logic [SIZE_W-1:0] stat_size_q, stat_size_d;
  logic              stat_vld_q, stat_vld_d;

`ifdef SHA256_CFG_JOIN_LAST_CHECK_EN
  assign id_wdat = {id_in_last, id_in};
`else
  // Without the check the ID last flag has nowhere to go.
  logic unused_id_last;
  assign unused_id_last = id_in_last;
  assign id_wdat        = id_in;
`endif
  assign cfg_wdat = {cfg_in_size, cfg_in_scheme, cfg_in_last};

  assign id_in_ready  = en & ~sync_rst & ~id_full;
  assign cfg_in_ready = en & ~sync_rst & ~cfg_full;
  assign id_push      = id_in_valid & id_in_ready;
  assign cfg_push     = cfg_in_valid & cfg_in_ready;
  assign hs           = en & out_vld_q & cfg_out_ready;
  assign load         = en & ~sync_rst & ~id_empty & ~cfg_empty & (~out_vld_q | cfg_out_ready);

  sha256_cfg_join_fifo #(.W(IW), .DEPTH(DEPTH)) u_id_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (sync_rst),
    .push  (id_push),
    .pop   (load),
    .wdat  (id_wdat),
    .rdat  (id_head),
    .full  (id_full),
    .empty (id_empty),
    .level (id_level)
  );

  sha256_cfg_join_fifo #(.W($bits(cfg_t)), .DEPTH(DEPTH)) u_cfg_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (sync_rst),
    .push  (cfg_push),
    .pop   (load),
    .wdat  (cfg_wdat),
    .rdat  (cfg_head),
    .full  (cfg_full),
    .empty (cfg_empty),
    .level (cfg_level)
  );

  // With en low every register holds; the record is re-presented once en returns.
  always_comb begin
    rec_d       = rec_q;
    out_vld_d   = out_vld_q;
    stat_size_d = stat_size_q;
    stat_vld_d  = stat_vld_q;
    if (sync_rst) begin
      rec_d       = '0;
      out_vld_d   = 1'b0;
      stat_size_d = '0;
      stat_vld_d  = 1'b0;
    end else if (en) begin
      stat_vld_d  = hs;
      stat_size_d = hs ? rec_q.cfg.size : '0;
      if (load) begin
        rec_d.cfg = cfg_head;
        rec_d.id  = id_head[ID_W-1:0];
        out_vld_d = 1'b1;
      end else if (hs) begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rec_q       <= '0;
      out_vld_q   <= 1'b0;
      stat_size_q <= '0;
      stat_vld_q  <= 1'b0;
    end else begin
      rec_q       <= rec_d;
      out_vld_q   <= out_vld_d;
      stat_size_q <= stat_size_d;
      stat_vld_q  <= stat_vld_d;
    end
  end

  assign cfg_out_size   = rec_q.cfg.size;
  assign cfg_out_scheme = rec_q.cfg.scheme;
  assign cfg_out_last   = rec_q.cfg.last;
  assign cfg_out_id     = rec_q.id;
  assign cfg_out_valid  = out_vld_q & en;
  assign status_size    = stat_size_q;
  assign status_valid   = stat_vld_q;

`ifdef SHA256_CFG_JOIN_LAST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (sync_rst) begin
      err_d = 1'b0;
    end else if (load && (id_head[ID_W] != cfg_head.last)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_last_mismatch = err_q;
`endif
endmodule
